// File: rtl/seg7_scan.sv
// seg7_scan: scans eight BCD digits onto a common-anode 7-seg display.
// Ports: clk, rst_n, digits/dp/blank/blink in; seg_n, an_n, frame_tick out.
module seg7_scan #(
    parameter int DIV          = 100000,
    parameter int DEAD         = 2000,
    parameter int BLINK_FRAMES = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digits,
    input  logic [7:0]  dp,
    input  logic [7:0]  blank,
    input  logic [7:0]  blink,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n,
    output logic        frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
    localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [FW-1:0] fcnt;
    logic          blink_phase;
    logic [31:0]   sh_digits;
    logic [7:0]    sh_dp;
    logic [7:0]    sh_blank;
    logic [7:0]    sh_blink;

    logic [3:0] code;
    logic [6:0] pat;
    logic       in_dead;
    logic       dark;
    logic       slot_end;
    logic       frame_end;

    // With no dead time the compare would be constant, so drop it.
    generate
        if (DEAD == 0) begin : g_nodead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt < CW'(DEAD));
        end
    endgenerate

    assign code      = sh_digits[{idx, 2'b00} +: 4];
    assign dark      = in_dead | sh_blank[idx] | (blink_phase & sh_blink[idx]);
    assign slot_end  = (cnt == CMAX);
    assign frame_end = slot_end && (idx == 3'd7);

    // Active-high pattern, bit order g..a.
    always_comb begin
        pat = 7'b0000000;
        case (code)
            4'd0:    pat = 7'b0111111;
            4'd1:    pat = 7'b0000110;
            4'd2:    pat = 7'b1011011;
            4'd3:    pat = 7'b1001111;
            4'd4:    pat = 7'b1100110;
            4'd5:    pat = 7'b1101101;
            4'd6:    pat = 7'b1111101;
            4'd7:    pat = 7'b0000111;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1101111;
            4'd10:   pat = 7'b1000000;
            default: pat = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blank    <= 8'hFF;
            sh_blink    <= '0;
            an_n        <= 8'hFF;
            seg_n       <= 8'hFF;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= (cnt == '0) && (idx == 3'd0);

            if (dark) begin
                an_n  <= 8'hFF;
                seg_n <= 8'hFF;
            end else begin
                an_n  <= ~(8'b1 << idx);
                seg_n <= ~{sh_dp[idx], pat};
            end

            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Snapshot once per frame so a frame never mixes old and new.
            if (frame_end) begin
                sh_digits <= digits;
                sh_dp     <= dp;
                sh_blank  <= blank;
                sh_blink  <= blink;
                if (fcnt == FMAX) begin
                    fcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan (DIV=4, DEAD=1, BLINK_FRAMES=2).
// Expectations are queued at each clock edge and checked on the falling edge.
module tb_seg7_scan;

    logic        clk;
    logic        rst_n;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  blink;
    logic [7:0]  seg_n;
    logic [7:0]  an_n;
    logic        frame_tick;

    seg7_scan #(.DIV(4), .DEAD(1), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dp         (dp),
        .blank      (blank),
        .blink      (blink),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   pos = -1;

    // Hand-computed active-low segment values, dp off.
    logic [7:0] segtab [16];
    initial begin
        segtab[0]  = 8'hC0; segtab[1]  = 8'hF9; segtab[2]  = 8'hA4;
        segtab[3]  = 8'hB0; segtab[4]  = 8'h99; segtab[5]  = 8'h92;
        segtab[6]  = 8'h82; segtab[7]  = 8'hF8; segtab[8]  = 8'h80;
        segtab[9]  = 8'h90; segtab[10] = 8'hBF; segtab[11] = 8'hFF;
        segtab[12] = 8'hFF; segtab[13] = 8'hFF; segtab[14] = 8'hFF;
        segtab[15] = 8'hFF;
    end

    logic [31:0] m_dig;
    logic [7:0]  m_dp, m_blank, m_blink;

    // Expected output per edge, from the cycle position since release.
    always @(posedge clk) begin
        exp_t e;
        int c, i, f;
        logic [3:0] cd;
        e = '{an: 8'hFF, seg: 8'hFF, tick: 1'b0};
        if (!rst_n) begin
            pos     = -1;
            m_dig   = '0;
            m_dp    = '0;
            m_blank = 8'hFF;
            m_blink = '0;
        end else begin
            pos = pos + 1;
            c = pos % 4;
            i = (pos / 4) % 8;
            f = pos / 32;
            e.tick = (c == 0) && (i == 0);
            if (!(c < 1 || m_blank[i] || (((f / 2) % 2) == 1 && m_blink[i]))) begin
                cd = m_dig[i*4 +: 4];
                e.an  = ~(8'h01 << i);
                e.seg = m_dp[i] ? (segtab[cd] & 8'h7F) : segtab[cd];
            end
            if ((pos % 32) == 31) begin
                m_dig   = digits;
                m_dp    = dp;
                m_blank = blank;
                m_blink = blink;
            end
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (!rst_n) e = '{an: 8'hFF, seg: 8'hFF, tick: 1'b0};
            checks++;
            if (an_n === e.an && seg_n === e.seg && frame_tick === e.tick)
                passed++;
            else
                $display("FAIL out t=%0t pos=%0d an_n=%h/%h seg_n=%h/%h tick=%b/%b",
                         $time, pos, an_n, e.an, seg_n, e.seg, frame_tick, e.tick);
        end
    end

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (pos < p && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (pos < p) begin
            checks++;
            $display("FAIL timeout pos=%0d want=%0d", pos, p);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        digits = 32'h76543210;
        dp     = 8'h00;
        blank  = 8'h00;
        blink  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Frame 1 shows 76543210; frame 2 zeros; frame 3 nines.
        wait_pos(40);
        digits = 32'h0;
        wait_pos(70);
        digits = 32'h99999999;

        // Blink on digit 0 from frame 4 onward.
        wait_pos(100);
        digits = 32'h00000008;
        blink  = 8'h01;

        // Change inputs in the capture cycle of frame 10.
        wait_pos(32 * 10 + 30);
        digits = 32'hFFFFFFBA;
        dp     = 8'hFF;
        blink  = 8'h00;

        wait_pos(32 * 12 + 30);
        blank = 8'hFF;

        wait_pos(32 * 13 + 10);
        blank  = 8'h00;
        dp     = 8'h00;
        digits = 32'h76543210;

        // Mid-slot reset during slot 5 of frame 14.
        wait_pos(32 * 14 + 21);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an_n === 8'hFF && seg_n === 8'hFF)
            passed++;
        else
            $display("FAIL async_rst an_n=%h/ff seg_n=%h/ff", an_n, seg_n);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_pos(70);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
